// File: rtl/gpio_seq_transactor.sv
// Table-driven GPIO handshake transactor: waits for masked patterns on the high
// half of a pad window and answers on the low half after a per-step delay.
module gpio_seq_transactor #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int DLY_W = 16,
    parameter int TO_W  = 20
) (
    input  logic                     clock,
    input  logic                     resetb,
    input  logic                     start,
    input  logic [$clog2(DEPTH):0]   num_steps,
    input  logic [TO_W-1:0]          timeout_limit,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [W-1:0]             prog_expect,
    input  logic [W-1:0]             prog_mask,
    input  logic [W-1:0]             prog_drive,
    input  logic                     prog_drive_en,
    input  logic [DLY_W-1:0]         prog_delay,
    input  logic [2*W-1:0]           pad_in,
    output logic [W-1:0]             pad_out,
    output logic                     pad_oe,
    output logic                     busy,
    output logic                     pass,
    output logic                     fail,
    output logic [$clog2(DEPTH)-1:0] step_idx
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DELAY,
        S_APPLY,
        S_DONE,
        S_FAIL
    } state_t;

    state_t           state;
    logic [W-1:0]     sync_q1;
    logic [W-1:0]     sync_hi;
    logic [TO_W-1:0]  to_cnt;
    logic [DLY_W-1:0] dly_cnt;
    logic [AW-1:0]    last_step;

    logic [W-1:0]     tbl_expect   [DEPTH];
    logic [W-1:0]     tbl_mask     [DEPTH];
    logic [W-1:0]     tbl_drive    [DEPTH];
    logic             tbl_drive_en [DEPTH];
    logic [DLY_W-1:0] tbl_delay    [DEPTH];

    // The low half is our own drive reflected back; it is never monitored.
    logic unused_low;
    assign unused_low = ^pad_in[W-1:0];

    // NOTE: the sequence table has no reset; software programs every entry it
    // uses before a start, so resetting it would only cost flops and routing.
    always_ff @(posedge clock) begin
        if (prog_we && !busy) begin
            tbl_expect[prog_addr]   <= prog_expect;
            tbl_mask[prog_addr]     <= prog_mask;
            tbl_drive[prog_addr]    <= prog_drive;
            tbl_drive_en[prog_addr] <= prog_drive_en;
            tbl_delay[prog_addr]    <= prog_delay;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sync_q1 <= '0;
            sync_hi <= '0;
        end else begin
            sync_q1 <= pad_in[2*W-1:W];
            sync_hi <= sync_q1;
        end
    end

    logic            match;
    logic [TO_W-1:0] to_next;
    logic            to_hit;
    logic [AW:0]     steps_clamped;
    logic [AW:0]     last_full;

    assign match         = ((sync_hi ^ tbl_expect[step_idx]) & tbl_mask[step_idx]) == '0;
    assign to_next       = (to_cnt == '1) ? to_cnt : to_cnt + TO_W'(1);
    assign to_hit        = (timeout_limit != '0) && (to_next >= timeout_limit);
    assign steps_clamped = (num_steps > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_steps;
    assign last_full     = steps_clamped - (AW+1)'(1);

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state     <= S_IDLE;
            pad_out   <= '0;
            pad_oe    <= 1'b0;
            busy      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            step_idx  <= '0;
            to_cnt    <= '0;
            dly_cnt   <= '0;
            last_step <= '0;
        end else begin
            unique case (state)
                // DONE and FAIL last one cycle and accept a start like IDLE.
                S_IDLE, S_DONE, S_FAIL: begin
                    state <= S_IDLE;
                    if (start) begin
                        step_idx <= '0;
                        to_cnt   <= '0;
                        dly_cnt  <= '0;
                        fail     <= 1'b0;
                        if (num_steps == '0) begin
                            state <= S_DONE;
                            pass  <= 1'b1;
                        end else begin
                            state     <= S_WAIT;
                            busy      <= 1'b1;
                            pass      <= 1'b0;
                            last_step <= last_full[AW-1:0];
                        end
                    end
                end
                S_WAIT: begin
                    if (match) begin
                        state   <= S_DELAY;
                        dly_cnt <= tbl_delay[step_idx];
                    end else begin
                        to_cnt <= to_next;
                        if (to_hit) begin
                            state  <= S_FAIL;
                            busy   <= 1'b0;
                            fail   <= 1'b1;
                            pad_oe <= 1'b0;
                        end
                    end
                end
                S_DELAY: begin
                    if (dly_cnt == '0) begin
                        state <= S_APPLY;
                    end else begin
                        dly_cnt <= dly_cnt - DLY_W'(1);
                    end
                end
                S_APPLY: begin
                    pad_out <= tbl_drive[step_idx];
                    pad_oe  <= tbl_drive_en[step_idx];
                    if (step_idx == last_step) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        pass  <= 1'b1;
                    end else begin
                        state    <= S_WAIT;
                        step_idx <= step_idx + AW'(1);
                        to_cnt   <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/gpio_seq_transactor.md
Name: gpio_seq_transactor

Overview:
- Synthesizable, table-driven GPIO handshake transactor and monitor for mgmt_soc GPIO tests.
- Drives the low half of a 2*W-bit pad window and watches the high half.
- Steps through a programmable sequence of expect-then-respond steps, with per-step masks, per-step response delays and a per-step timeout.
- Reports pass or fail, and the failing step.
- Generalises the fixed 8-bit, hard-coded checkbits handshake to any width and sequence depth. Adds masked matching, output release and timeout detection.

Parameters:
- W, 8, width of each half of the checkbits window (pad window is 2*W).
- DEPTH, 16, number of sequence table entries (power of 2, at least 2).
- DLY_W, 16, width of the per-step response delay field.
- TO_W, 20, width of the timeout limit and timeout counter.

Ports:
- clock  input  1  system clock.
- resetb  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins the sequence at step 0. Ignored while busy.
- num_steps  input  $clog2(DEPTH)+1  number of steps to run, 1..DEPTH. A value of 0 gives an immediate pass.
- timeout_limit  input  TO_W  maximum wait cycles per step. 0 disables the timeout.
- prog_we  input  1  table write strobe. Ignored while busy.
- prog_addr  input  $clog2(DEPTH)  table entry to write.
- prog_expect  input  W  value the high half must match.
- prog_mask  input  W  compare mask (1 = bit compared).
- prog_drive  input  W  value driven on the low half once the step completes.
- prog_drive_en  input  1  1 = drive prog_drive; 0 = release the low half (oe low).
- prog_delay  input  DLY_W  cycles between match and drive.
- pad_in  input  2*W  sampled pad window. [2W-1:W] is the DUT-driven high half.
- pad_out  output  W  value for the low half.
- pad_oe  output  1  output enable for pad_out.
- busy  output  1  sequence in progress.
- pass  output  1  sticky; sequence completed.
- fail  output  1  sticky; a timeout occurred.
- step_idx  output  $clog2(DEPTH)  current step (or the failing step once failed).

Behaviour:
- Reset values: pad_out = 0, pad_oe = 0, busy = 0, pass = 0, fail = 0, step_idx = 0, FSM = IDLE. Table contents are not reset.
- Input sync: pad_in[2W-1:W] passes through a 2-flop synchronizer. All comparisons use the synchronized value, so match latency is 2 cycles from the pad change.
- Table write: an entry is written on the clock edge where prog_we = 1 and busy = 0.
- States:
  - IDLE:
    - start with num_steps = 0 -> DONE; pass = 1 the next cycle.
    - start otherwise -> WAIT; busy = 1; step_idx = 0; timeout counter and delay counter cleared; pass and fail cleared.
  - WAIT:
    - Each cycle, test whether (sync_hi & mask) == (expect & mask).
    - Match -> DELAY; delay counter loaded with the entry's delay.
    - No match -> timeout counter increments.
    - If timeout_limit != 0 and the counter reaches timeout_limit in the same cycle without a match -> FAIL.
    - A match in the same cycle as the timeout wins: no fail.
  - DELAY:
    - Counter decrements each cycle.
    - At 0 -> APPLY. A delay of 0 goes to APPLY in the next cycle.
  - APPLY (one cycle):
    - pad_out = drive and pad_oe = drive_en, registered; both hold until the next APPLY or until reset.
    - If step_idx == num_steps-1 -> DONE.
    - Otherwise step_idx increments, the timeout counter clears, and the FSM returns to WAIT.
  - DONE: busy = 0; pass = 1 (sticky); -> IDLE.
  - FAIL: busy = 0; fail = 1 (sticky); step_idx frozen at the failing step; pad_oe forced to 0; -> IDLE.
- Outputs after a sequence: pass and fail stay set until the next accepted start or reset. pad_out and pad_oe keep their last applied values after DONE.
- A step_idx wrap past DEPTH-1 is impossible because num_steps ≤ DEPTH; a num_steps > DEPTH is clamped to DEPTH.
- start while busy: ignored, with no effect on state.
- resetb asserted mid-sequence: every output returns to its reset value immediately (asynchronously), including pad_oe = 0.
- The timeout counter saturates at all-ones and never wraps.
- Per-step latency: synchronized match to pad_out update = delay + 2 cycles (DELAY exit plus the APPLY register).

Test Plan:
- Base handshake:
  - Stimulus: W=8; 3 steps, expect A0/0B/AB, mask FF, drive F0/0F/00, delay 0; the bench drives the high half to A0, 0B, AB in turn after each response.
  - Required: pad_out shows F0, 0F, 00; pass = 1; fail = 0; step_idx = 2.
- Delay timing:
  - Stimulus: step with delay 3000, drive 01.
  - Required: pad_out changes exactly 3002 cycles after the synchronized match.
- Masked match and release:
  - Stimulus: expect 04, mask 0F, high half = F4, drive_en = 0.
  - Required: match; pad_oe = 0; pass.
- Timeout:
  - Stimulus: timeout_limit = 100; step 1 never matches.
  - Required: fail = 1 at cycle 100 of WAIT; step_idx = 1; pad_oe = 0; pass = 0.
- Timeout disabled and match/timeout tie:
  - Stimulus: limit = 0 with no match for 5000 cycles, then match.
  - Required: no fail; sequence continues.
  - Stimulus: match arriving in the same cycle the counter hits the limit.
  - Required: no fail.
- Reset and start robustness:
  - Stimulus: resetb low during DELAY.
  - Required: all outputs at reset values immediately; a new start then runs from step 0.
  - Stimulus: start pulse while busy.
  - Required: ignored.
